// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR with a returned sideband tag.
// Shift steps are split into STAGES contiguous groups, each followed by a register bank.
module shift_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [XLEN-1:0]          in_a,
  input  logic [$clog2(XLEN)-1:0]  in_b,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [TAGW-1:0]          out_tag
);

  localparam int SHW = $clog2(XLEN);
  // Steps per group; the last group simply ends at SHW.
  localparam int GRP = (SHW + STAGES - 1) / STAGES;

  if (!(XLEN == 32 || XLEN == 64) || STAGES < 1 || STAGES > SHW) begin : g_param_check
    $error("shift_pipe: XLEN must be 32/64 and STAGES in 1..log2(XLEN)");
  end

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  typedef struct packed {
    logic            valid;
    logic [2:0]      op;
    logic [SHW-1:0]  rem;
    logic [XLEN-1:0] data;
    logic [TAGW-1:0] tag;
  } stage_t;

  // SRA sees the original sign in data[XLEN-1] at every step, since earlier
  // arithmetic steps preserve the MSB. Reserved ops pass data through.
  function automatic logic [XLEN-1:0] shift_step(logic [2:0] op, logic [XLEN-1:0] d,
                                                 int unsigned n);
    case (op)
      OP_SLL:  return d << n;
      OP_SRL:  return d >> n;
      OP_SRA:  return $signed(d) >>> n;
      OP_ROL:  return (d << n) | (d >> (XLEN - n));
      OP_ROR:  return (d >> n) | (d << (XLEN - n));
      default: return d;
    endcase
  endfunction

  function automatic stage_t apply_group(int s, stage_t st);
    stage_t r;
    r = st;
    for (int j = 0; j < SHW; j++) begin
      if (j >= s * GRP && j < (s + 1) * GRP && r.rem[j]) begin
        r.data   = shift_step(r.op, r.data, 1 << j);
        r.rem[j] = 1'b0;
      end
    end
    return r;
  endfunction

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t in_pkt;
  logic   advance;

  // Whole-pipe stall: no bubble compression, every bank moves or none does.
  assign advance  = !stage_q[STAGES-1].valid || out_ready;
  assign in_ready = rst_n && !flush && advance;

  assign in_pkt = '{valid: in_valid && in_ready, op: in_op, rem: in_b, data: in_a, tag: in_tag};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t src;
    if (s == 0) begin : g_first
      assign src = in_pkt;
    end else begin : g_next
      assign src = stage_q[s-1];
    end
    assign stage_d[s] = apply_group(s, src);
  end

  // NOTE: sequential state uses non-blocking assignments so every bank samples
  // the previous bank's value, not one already updated in this same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data and tag are reset too, because the output stage must read
      // zero after reset; the cost is small as these are flops, not a memory.
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < STAGES; s++) stage_q[s].valid <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= stage_d[s];
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_data  = stage_q[STAGES-1].data;
  assign out_tag   = stage_q[STAGES-1].tag;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (XLEN=32, STAGES=2): directed vectors,
// latency/stall/flush/reset scenarios and a randomized backpressure run.
module tb_shift_pipe;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAGW   = 5;
  localparam int SHW    = 5;

  localparam logic [2:0] SLL = 3'd0;
  localparam logic [2:0] SRL = 3'd1;
  localparam logic [2:0] SRA = 3'd2;
  localparam logic [2:0] ROL = 3'd3;
  localparam logic [2:0] ROR = 3'd4;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a, out_data;
  logic [SHW-1:0]  in_b;
  logic [TAGW-1:0] in_tag, out_tag;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   n0;

  always #5 clk = ~clk;

  shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: whole-amount shifts, independent of the stepwise structure.
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [4:0] b);
    case (op)
      SLL:     return a << b;
      SRL:     return a >> b;
      SRA:     return $signed(a) >>> b;
      ROL:     return (a << b) | (a >> (6'd32 - {1'b0, b}));
      ROR:     return (a >> b) | (a << (6'd32 - {1'b0, b}));
      default: return a;
    endcase
  endfunction

  // Output monitor: pop on transfer, then drop everything killed by flush/reset.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_tag", out_tag, mon_e.tag);
      end
    end
    if (flush || !rst_n) sb.delete();
  end

  task automatic send(logic [2:0] op, logic [31:0] a, logic [4:0] b, logic [4:0] tag,
                      logic [31:0] exp);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) sb.push_back('{data: exp, tag: tag});
    else check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(logic [2:0] op, logic [31:0] a, logic [4:0] b, logic [4:0] tag);
    send(op, a, b, tag, model(op, a, b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // Latency: accepted in cycle 0, result visible in cycle 2
    send(SLL, 32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000);
    @(negedge clk);
    check("lat_c1_valid", out_valid, 0);
    step();
    @(negedge clk);
    check("lat_c2_valid", out_valid, 1);
    check("lat_c2_data", out_data, 32'h8000_0000);
    check("lat_c2_tag", out_tag, 7);
    step();

    // Back-to-back directed vectors, one result per cycle
    n0 = n_out;
    send(SRA, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000);
    send(SRL, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000);
    send(ROR, 32'h0000_00F1, 5'd4, 5'd3, 32'h1000_000F);
    send(ROL, 32'h8000_0001, 5'd1, 5'd4, 32'h0000_0003);
    for (int op = 0; op < 8; op++) begin
      a = 32'hDEAD_BEEF ^ 32'(op);
      send(3'(op), a, 5'd0, 5'(8 + op), a);
    end
    for (int op = 5; op < 8; op++) send(3'(op), 32'h1234_5678, 5'd13, 5'(16 + op), 32'h1234_5678);
    repeat (2) step();
    check("b2b_count", n_out - n0, 15);

    // Stall: three back-to-back, out_ready low for three cycles from cycle 2
    n0 = n_out;
    fork
      begin
        send_m(SLL, 32'h0000_0101, 5'd3, 5'd1);
        send_m(SRA, 32'h9000_0000, 5'd9, 5'd2);
        send_m(ROR, 32'h0000_ABCD, 5'd17, 5'd3);
      end
      begin
        repeat (2) step();
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
        end
        step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    check("stall_count", n_out - n0, 3);

    // Flush with two ops in flight and the output stalled
    send_m(SRL, 32'hF0F0_1234, 5'd3, 5'd10);
    send_m(SLL, 32'h0F0F_4321, 5'd2, 5'd11);
    n0 = n_out;
    out_ready = 1'b0; flush = 1'b1;
    in_valid = 1'b1; in_op = SLL; in_a = 32'h5555_5555; in_b = 5'd1; in_tag = 5'd12;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; out_ready = 1'b1;
    in_op = ROR; in_a = 32'h1357_9BDF; in_b = 5'd12; in_tag = 5'd13;
    @(negedge clk);
    check("flush_c3_valid", out_valid, 0);
    check("flush_c3_in_ready", in_ready, 1);
    if (in_ready) sb.push_back('{data: model(ROR, 32'h1357_9BDF, 5'd12), tag: 5'd13});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_c4_valid", out_valid, 0);
    step();
    @(negedge clk);
    check("flush_c5_valid", out_valid, 1);
    step();
    check("flush_count", n_out - n0, 1);

    // Reset with a full pipeline and the output stalled
    send_m(ROL, 32'hC000_0003, 5'd7, 5'd20);
    send_m(SRA, 32'hA5A5_A5A5, 5'd21, 5'd21);
    out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    n0 = n_out;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_out_tag", out_tag, 0);
    check("rst_mid_in_ready", in_ready, 1);
    repeat (4) step();
    check("rst_mid_no_output", n_out - n0, 0);

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++)
          send_m(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      begin
        repeat (120) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
    check("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter STAGES, default 2, number of pipeline register stages; legal range 1..log2(XLEN).
REQ-003 Parameter TAGW, default 5, width of the sideband tag (destination register index).
REQ-004 clk  input  1  single clock; every register updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous kill of all in-flight operations.
REQ-007 in_valid  input  1  input operation present.
REQ-008 in_ready  output  1  block accepts the input this cycle.
REQ-009 in_op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101..111 reserved.
REQ-010 in_a  input  XLEN  operand to shift.
REQ-011 in_b  input  log2(XLEN)  shift amount (already masked by the caller to shamt width).
REQ-012 in_tag  input  TAGW  sideband, returned unmodified with the result.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 out_data  output  XLEN  shift result.
REQ-016 out_tag  output  TAGW  tag of the operation in out_data.

Function
REQ-017 Input transfer occurs on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-018 Shift amount bits are processed LSB first in log2(XLEN) binary steps (1,2,4,...,XLEN/2); step k applied only when in_b[k]=1.
REQ-019 Steps are partitioned into STAGES contiguous groups of ceil(log2(XLEN)/STAGES) steps, LSB group first; the last group takes any remainder; one register bank follows each group.
REQ-020 Each stage register holds valid, op, remaining shift bits, partial data, tag.
REQ-021 Latency: result of an accepted input appears on out_valid/out_data exactly STAGES cycles after the transfer cycle, absent stall.
REQ-022 Throughput: one operation per cycle while out_ready=1.
REQ-023 Stall: when out_valid=1 and out_ready=0 the whole pipeline holds; in_ready = !out_valid || out_ready; no bubble compression required.
REQ-024 Bubbles (invalid stages) advance normally when not stalled; data in invalid stages is don't-care.
REQ-025 SLL/SRL fill vacated bits with 0; SRA fills with original in_a[XLEN-1]; ROL/ROR wrap bits around; all arithmetic is modulo XLEN bits, no overflow flag.
REQ-026 in_b=0 yields out_data=in_a for every op.
REQ-027 Reserved ops yield out_data=in_a unchanged, tag still returned.
REQ-028 Results emerge in acceptance order; no reordering.
REQ-029 flush=1 clears every stage valid bit next edge, including a result currently stalled on the output; in_ready=0 during flush cycle, the input that cycle is not accepted.
REQ-030 flush and stall simultaneous: flush wins.

Reset
REQ-031 rst_n=0 at a rising edge clears all valid bits; after that edge out_valid=0, out_data=0, out_tag=0.
REQ-032 in_ready=0 while rst_n=0; in_ready=1 on the first cycle after rst_n returns high.
REQ-033 Reset mid-operation discards all in-flight operations; none appear after reset.
REQ-034 Reset has priority over flush and handshake.

Verification (XLEN=32, STAGES=2, out_ready=1 unless stated)
REQ-035 SLL a=0x00000001 b=31 tag=7 at cycle 0 -> cycle 2 out_valid=1, out_data=0x80000000, out_tag=7.
REQ-036 SRA a=0x80000000 b=4 -> 0xF8000000; SRL same operands -> 0x08000000; back-to-back, consecutive output cycles.
REQ-037 ROR a=0x000000F1 b=4 -> 0x1000000F; ROL a=0x80000001 b=1 -> 0x00000003; b=0 any op -> a.
REQ-038 Three back-to-back inputs (tags 1,2,3), out_ready=0 from cycle 2 for 3 cycles -> in_ready=0 while stalled, tags 1,2,3 delivered in order, none lost or duplicated.
REQ-039 Two ops in flight, flush=1 one cycle -> no out_valid for those ops; op accepted the following cycle emerges 2 cycles later correctly.
REQ-040 rst_n=0 one cycle with pipeline full and output stalled -> out_valid=0, out_data=0 next cycle; in_ready=1 after release.
